branch_redirect_unit: RTL and testbench



---
 rtl/pipeline_pkg.sv | 19 +
 rtl/branch_redirect_unit_if.sv | 31 +++
 rtl/wrap_counter.sv | 27 ++
 rtl/branch_redirect_unit.sv | 111 +++++++++++
 tb/tb_branch_redirect_unit.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: data width, redirect vectors and the
// redirect FSM state type used by branch_redirect_unit.
package pipeline_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  // Word addresses loaded into the PC at boot and on a trap.
  localparam word_t RESET_VECTOR_DEF = 32'h0000_0000;
  localparam word_t TRAP_VECTOR_DEF  = 32'h0000_0100;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    SQUASH = 2'd2
  } redirect_state_t;

endpackage

// File: rtl/branch_redirect_unit_if.sv
// Execute-side bus of the redirect unit.
//   ex_valid/ex_is_branch/ex_taken/ex_target/trap : resolved instruction info
//   newPC/branchEnable                              : redirect to the PC
//   squash                                          : invalidate younger stages
//   redirect_count/branch_count                     : performance counters
// master = execute stage / PC side, slave = branch_redirect_unit.
interface branch_redirect_unit_if;
  import pipeline_pkg::*;

  logic  ex_valid;
  logic  ex_is_branch;
  logic  ex_taken;
  word_t ex_target;
  logic  trap;
  word_t newPC;
  logic  branchEnable;
  logic  squash;
  word_t redirect_count;
  word_t branch_count;

  modport master (
    output ex_valid, ex_is_branch, ex_taken, ex_target, trap,
    input  newPC, branchEnable, squash, redirect_count, branch_count
  );

  modport slave (
    input  ex_valid, ex_is_branch, ex_taken, ex_target, trap,
    output newPC, branchEnable, squash, redirect_count, branch_count
  );

endinterface

// File: rtl/wrap_counter.sv
// Free-running event counter that wraps from all-ones to zero.
//   clk   : clock
//   clr_n : synchronous active-low clear
//   en    : count this cycle
//   count : current value
module wrap_counter
  import pipeline_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  // NOTE: clear is sampled on the clock edge only; it is not in the
  // sensitivity list, so this is a synchronous clear.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/branch_redirect_unit.sv
// Branch/trap redirect unit beside the execute stage.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of branch_redirect_unit_if
// Drives the PC with the boot vector, taken-branch targets and the trap
// vector in the same cycle the event is seen, then squashes PIPE_DEPTH
// cycles of wrong-path instructions. Counts redirects and correct-path
// branches.
module branch_redirect_unit
  import pipeline_pkg::*;
#(
  parameter word_t       RESET_VECTOR = RESET_VECTOR_DEF,
  parameter word_t       TRAP_VECTOR  = TRAP_VECTOR_DEF,
  parameter int unsigned PIPE_DEPTH   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  branch_redirect_unit_if.slave  bus
);

  localparam logic [3:0] SQ_LOAD = 4'(PIPE_DEPTH);

  redirect_state_t state;
  logic [3:0]      sq_cnt;

  logic take_trap;
  logic take_branch;
  logic redirect;
  logic count_branch;

  // Qualifiers only matter when execute holds a live instruction and the
  // unit is not squashing; trap wins over a simultaneous taken branch.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned, which would infer a latch.
    take_trap        = 1'b0;
    take_branch      = 1'b0;
    count_branch     = 1'b0;
    bus.branchEnable = 1'b0;
    bus.newPC        = '0;
    bus.squash       = 1'b0;

    // Reset held low presents the boot redirect whatever state holds.
    if (!rst_n || state == BOOT) begin
      bus.branchEnable = 1'b1;
      bus.newPC        = RESET_VECTOR;
      bus.squash       = 1'b1;
    end else if (state == SQUASH) begin
      bus.squash       = 1'b1;
    end else begin
      take_trap    = bus.ex_valid & bus.trap;
      take_branch  = bus.ex_valid & bus.ex_is_branch & bus.ex_taken & ~bus.trap;
      count_branch = bus.ex_valid & bus.ex_is_branch & ~bus.trap;
      if (take_trap) begin
        bus.branchEnable = 1'b1;
        bus.newPC        = TRAP_VECTOR;
      end else if (take_branch) begin
        bus.branchEnable = 1'b1;
        bus.newPC        = bus.ex_target;
      end
    end
  end

  assign redirect = take_trap | take_branch;

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= BOOT;
      sq_cnt <= '0;
    end else begin
      unique case (state)
        BOOT: begin
          state  <= SQUASH;
          sq_cnt <= SQ_LOAD;
        end
        RUN: begin
          if (redirect) begin
            state  <= SQUASH;
            sq_cnt <= SQ_LOAD;
          end
        end
        SQUASH: begin
          sq_cnt <= sq_cnt - 4'd1;
          if (sq_cnt == 4'd1) begin
            state <= RUN;
          end
        end
        default: begin
          state  <= BOOT;
          sq_cnt <= '0;
        end
      endcase
    end
  end

  wrap_counter #(.WIDTH(XLEN)) u_redirect_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .en    (redirect),
    .count (bus.redirect_count)
  );

  wrap_counter #(.WIDTH(XLEN)) u_branch_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .en    (count_branch),
    .count (bus.branch_count)
  );

endmodule

// File: tb/tb_branch_redirect_unit.sv
module tb_branch_redirect_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam logic [31:0] TV    = 32'h0000_0100;

  typedef struct packed {
    logic        rst;
    logic        v;
    logic        br;
    logic        tk;
    logic        tr;
    logic [31:0] tgt;
  } in_t;

  typedef struct packed {
    logic        be;
    logic [31:0] pc;
    logic        sq;
    logic [31:0] rc;
    logic [31:0] bc;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  branch_redirect_unit_if bus ();

  branch_redirect_unit #(
    .RESET_VECTOR (RV),
    .TRAP_VECTOR  (TV),
    .PIPE_DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: booting flag, squash cycles still owed, event tallies.
  bit          m_boot = 1'b1;
  int          m_sq_left = 0;
  logic [31:0] m_rc = '0;
  logic [31:0] m_bc = '0;

  function automatic exp_t model_out(input in_t i);
    exp_t e;
    e    = '0;
    e.rc = m_rc;
    e.bc = m_bc;
    if (!i.rst || m_boot) begin
      e.be = 1'b1; e.pc = RV; e.sq = 1'b1;
    end else if (m_sq_left > 0) begin
      e.sq = 1'b1;
    end else if (i.v && i.tr) begin
      e.be = 1'b1; e.pc = TV;
    end else if (i.v && i.br && i.tk) begin
      e.be = 1'b1; e.pc = i.tgt;
    end
    return e;
  endfunction

  task automatic model_edge(input in_t i);
    if (!i.rst) begin
      m_boot = 1'b1; m_sq_left = 0; m_rc = '0; m_bc = '0;
    end else if (m_boot) begin
      m_boot = 1'b0; m_sq_left = DEPTH;
    end else if (m_sq_left > 0) begin
      m_sq_left = m_sq_left - 1;
    end else if (i.v) begin
      if (i.tr || (i.br && i.tk)) begin
        m_rc = m_rc + 1;
        m_sq_left = DEPTH;
      end
      if (i.br && !i.tr) m_bc = m_bc + 1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs applied 1 time unit after posedge, outputs sampled mid-cycle.
  task automatic run_cycle(input in_t i, input exp_t e, input string tag);
    rst_n            = i.rst;
    bus.ex_valid     = i.v;
    bus.ex_is_branch = i.br;
    bus.ex_taken     = i.tk;
    bus.trap         = i.tr;
    bus.ex_target    = i.tgt;
    #2;
    check({tag, " branchEnable"},   32'(bus.branchEnable), 32'(e.be));
    check({tag, " newPC"},          bus.newPC,             e.pc);
    check({tag, " squash"},         32'(bus.squash),       32'(e.sq));
    check({tag, " redirect_count"}, bus.redirect_count,    e.rc);
    check({tag, " branch_count"},   bus.branch_count,      e.bc);
    @(posedge clk);
    model_edge(i);
    #1;
  endtask

  function automatic in_t mk_in(input logic r, v, br, tk, tr, input logic [31:0] tgt);
    in_t i;
    i.rst = r; i.v = v; i.br = br; i.tk = tk; i.tr = tr; i.tgt = tgt;
    return i;
  endfunction

  function automatic exp_t mk_exp(input logic be, input logic [31:0] pc, input logic sq,
                                  input logic [31:0] rc, bc);
    exp_t e;
    e.be = be; e.pc = pc; e.sq = sq; e.rc = rc; e.bc = bc;
    return e;
  endfunction

  vec_t vecs[21];

  initial begin
    in_t i;
    exp_t e;

    // Hand-derived expectations; counters show values before the edge.
    vecs[0]  = '{mk_in(0,1,1,1,0,32'h55), mk_exp(1,RV,1,0,0)};       // reset, ex ignored
    vecs[1]  = '{mk_in(0,0,0,0,0,32'h0),  mk_exp(1,RV,1,0,0)};
    vecs[2]  = '{mk_in(0,1,0,0,1,32'h0),  mk_exp(1,RV,1,0,0)};
    vecs[3]  = '{mk_in(1,1,1,1,0,32'h77), mk_exp(1,RV,1,0,0)};       // first rst_n=1 cycle
    vecs[4]  = '{mk_in(1,0,0,0,0,32'h0),  mk_exp(0,0,1,0,0)};        // boot squash 1
    vecs[5]  = '{mk_in(1,0,0,0,0,32'h0),  mk_exp(0,0,1,0,0)};        // boot squash 2
    vecs[6]  = '{mk_in(1,1,1,1,0,32'h40), mk_exp(1,32'h40,0,0,0)};   // taken branch
    vecs[7]  = '{mk_in(1,0,0,0,0,32'h0),  mk_exp(0,0,1,1,1)};
    vecs[8]  = '{mk_in(1,0,0,0,0,32'h0),  mk_exp(0,0,1,1,1)};
    vecs[9]  = '{mk_in(1,1,1,0,0,32'h99), mk_exp(0,0,0,1,1)};        // not taken
    vecs[10] = '{mk_in(1,1,1,1,1,32'h44), mk_exp(1,TV,0,1,2)};       // trap beats branch
    vecs[11] = '{mk_in(1,1,1,1,0,32'h80), mk_exp(0,0,1,2,2)};        // wrong path
    vecs[12] = '{mk_in(1,1,0,0,1,32'h0),  mk_exp(0,0,1,2,2)};        // wrong-path trap
    vecs[13] = '{mk_in(1,0,0,0,0,32'h0),  mk_exp(0,0,0,2,2)};        // RUN again
    vecs[14] = '{mk_in(1,0,1,1,1,32'h12), mk_exp(0,0,0,2,2)};        // no ex_valid
    vecs[15] = '{mk_in(1,1,1,1,0,32'h20), mk_exp(1,32'h20,0,2,2)};   // target == fall-through
    vecs[16] = '{mk_in(0,1,1,1,0,32'h33), mk_exp(1,RV,1,3,3)};       // reset mid-squash
    vecs[17] = '{mk_in(1,0,0,0,0,32'h0),  mk_exp(1,RV,1,0,0)};       // BOOT
    vecs[18] = '{mk_in(1,0,0,0,0,32'h0),  mk_exp(0,0,1,0,0)};
    vecs[19] = '{mk_in(1,0,0,0,0,32'h0),  mk_exp(0,0,1,0,0)};
    vecs[20] = '{mk_in(1,0,0,0,0,32'h0),  mk_exp(0,0,0,0,0)};

    // Pre-cycle so the synchronous reset has cleared the counters.
    i = mk_in(0,0,0,0,0,32'h0);
    rst_n = 1'b0;
    bus.ex_valid = 1'b0; bus.ex_is_branch = 1'b0; bus.ex_taken = 1'b0;
    bus.trap = 1'b0; bus.ex_target = '0;
    @(posedge clk);
    model_edge(i);
    #1;

    for (int k = 0; k < 21; k++) begin
      run_cycle(vecs[k].i, vecs[k].e, $sformatf("vec%0d", k));
    end

    // Wrap: preload redirect counter to all-ones, then one taken branch.
    force dut.u_redirect_cnt.count = 32'hFFFF_FFFF;
    #1;
    release dut.u_redirect_cnt.count;
    m_rc = 32'hFFFF_FFFF;
    i = mk_in(1,1,1,1,0,32'h200);
    run_cycle(i, mk_exp(1,32'h200,0,32'hFFFF_FFFF,0), "wrap pre");
    i = mk_in(1,0,0,0,0,32'h0);
    run_cycle(i, mk_exp(0,0,1,0,1), "wrap post");

    // Randomised traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      i.rst = ($urandom_range(0, 29) != 0);
      i.v   = ($urandom_range(0, 3) != 0);
      i.br  = 1'($urandom_range(0, 1));
      i.tk  = 1'($urandom_range(0, 1));
      i.tr  = ($urandom_range(0, 7) == 0);
      i.tgt = $urandom;
      e = model_out(i);
      run_cycle(i, e, $sformatf("rand%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
